psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream consumer of the last systolic row: takes the per-lane partial-sum vector res_mac_n from the sub-MAC chain.
- Sign/zero-extends each lane and accumulates a runtime-set number of beats (reduction depth K).
- Pushes each completed K-beat sum into a small output FIFO drained with valid/ready toward the writeback/activation stage.

Parameters:
- bit_width, 8, lane width of incoming partial sums
- LANES, 8, number of lanes in res_mac_n
- ACC_W, 24, accumulator width per lane (ACC_W > bit_width)
- LEN_W, 8, width of acc_len / beat counter
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- ce  in  1  global enable; when 0 no state changes
- in_valid  in  1  res_mac_n beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- res_mac_n  in  bit_width*LANES  partial sums, lane i = bits [(i+1)*bit_width-1 : i*bit_width]
- acc_len  in  LEN_W  beats per group K; 0 treated as 1
- signed_mode  in  1  1 = sign-extend lanes, 0 = zero-extend
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer ready
- out_data  out  ACC_W*LANES  FIFO head, lane i at [(i+1)*ACC_W-1 : i*ACC_W]
- beat_cnt  out  LEN_W  beats accepted in current group
- ovf  out  1  sticky overflow, any lane, any group

Behaviour:
- Reset (reset=0 at posedge): acc lanes=0, beat_cnt=0, FIFO empty, out_valid=0, ovf=0, latched length=1. Reset wins over every other event, including mid-group and FIFO non-empty; discarded data is lost.
- in_ready = ce & (fifo_count < FIFO_DEPTH). Combinational, no dependence on out_ready.
- Accept = ce & in_valid & in_ready.
- Group start (beat_cnt==0 on accept):
  - latch K = max(acc_len,1) and signed_mode for the whole group.
  - Mid-group changes to acc_len/signed_mode are ignored.
- Per accepted beat, lane i:
  - ext = latched-sign-extend or zero-extend of the bit_width-bit lane to ACC_W.
  - sum = (beat_cnt==0 ? 0 : acc[i]) + ext, modulo 2^ACC_W (wrap, no saturation).
- Non-final beat (beat_cnt+1 < K): acc <= sum; beat_cnt <= beat_cnt+1.
- Final beat (beat_cnt+1 == K):
  - push {sum lanes} into FIFO; beat_cnt <= 0; acc <= sum (held, don't-care).
  - K=1 pushes every accepted beat.
- Overflow:
  - signed: addends same sign and sum sign differs.
  - unsigned: carry out of bit ACC_W-1.
  - Any lane, any beat sets ovf=1; ovf clears only on reset.
- Output FIFO:
  - out_valid = fifo_count != 0; out_data = head entry, registered, stable while out_valid & ~out_ready.
  - Pop = ce & out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged, both occur.
  - Full: in_ready=0, so no push; a pop that cycle frees space visible next cycle.
  - Empty: no pop; out_data holds last value.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: final beat accepted at edge N -> entry visible, out_valid=1 after edge N (cycle N+1) when FIFO was empty. Throughput is 1 beat/cycle while not full.
- ce=0: no accept, no pop, all registers hold; in_ready=0; out_valid still reflects FIFO state.

Test Plan:
- Reset, K=4, signed_mode=1, all lanes +3 for 4 beats, out_ready=1 -> one entry, every lane 12; out_valid high exactly one cycle after 4th accept; beat_cnt sequence 0,1,2,3,0.
- Signed extension, K=2, lanes 0xFF then 0x01 -> lanes 0; same with signed_mode=0 -> lanes 256; ovf stays 0.
- Backpressure: K=1, out_ready=0, 5 beats offered -> 4 accepted, in_ready=0 while full. Then out_ready=1 -> entries pop in order, in_ready returns the cycle after the first pop. A push+pop cycle keeps the count constant.
- Mid-group acc_len change 4->2 after beat 1 -> group still closes after 4 beats; next group uses K=2. acc_len=0 -> push on every beat.
- ACC_W overflow: ACC_W=10 instance, signed, K=8, lanes 0x7F -> sum 1016 wraps to -8 (0x3F8) and ovf=1 sticky; ovf=0 after reset.
- Reset mid-group (beat_cnt=2) with 2 FIFO entries -> next cycle out_valid=0, beat_cnt=0, ovf=0; a fresh K=2 group produces a correct sum with no residue. ce=0 for 3 cycles mid-group freezes beat_cnt and out_data.

Source files
------------

// File: rtl/psum_accumulator.sv
// Accumulates K beats of per-lane partial sums from the last systolic row and
// queues each finished group in a small valid/ready output FIFO.
module psum_accumulator #(
    parameter int bit_width  = 8,
    parameter int LANES      = 8,
    parameter int ACC_W      = 24,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [bit_width*LANES-1:0] res_mac_n,
    input  logic [LEN_W-1:0]         acc_len,
    input  logic                     signed_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W*LANES-1:0]   out_data,
    output logic [LEN_W-1:0]         beat_cnt,
    output logic                     ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH = FIFO_DEPTH;
    localparam logic [LEN_W-1:0] LEN_ONE   = 1;
    localparam logic [LEN_W:0]   BEAT_ONE  = 1;

    logic [ACC_W-1:0]       acc [LANES];
    logic [LEN_W-1:0]       group_len;
    logic                   group_signed;

    logic [ACC_W*LANES-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_count;

    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   first_beat;
    logic                   last_beat;
    logic                   beat_signed;
    logic [LEN_W-1:0]       beat_len;
    logic [LEN_W:0]         beat_next;
    logic [LANES-1:0]       lane_ovf;
    logic [ACC_W-1:0]       sum [LANES];
    logic [ACC_W*LANES-1:0] sum_vec;

    logic [CNT_W-1:0]       count_next;
    logic [PTR_W-1:0]       next_rd;
    logic [ACC_W*LANES-1:0] head_next;

    assign in_ready  = ce && (fifo_count < CNT_DEPTH);
    assign out_valid = (fifo_count != '0);
    assign accept    = ce && in_valid && in_ready;
    assign pop       = ce && out_valid && out_ready;

    // The first beat of a group uses the live length/mode; later beats use the latched copy.
    assign first_beat  = (beat_cnt == '0);
    assign beat_len    = first_beat ? ((acc_len == '0) ? LEN_ONE : acc_len) : group_len;
    assign beat_signed = first_beat ? signed_mode : group_signed;
    assign beat_next   = {1'b0, beat_cnt} + BEAT_ONE;
    assign last_beat   = (beat_next >= {1'b0, beat_len});
    assign push        = accept && last_beat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [bit_width-1:0] lane;
        logic [ACC_W-1:0]     ext;
        logic [ACC_W-1:0]     base;
        logic [ACC_W:0]       wide;

        assign lane = res_mac_n[i*bit_width +: bit_width];
        assign ext  = beat_signed ? {{(ACC_W-bit_width){lane[bit_width-1]}}, lane}
                                  : {{(ACC_W-bit_width){1'b0}}, lane};
        assign base = first_beat ? '0 : acc[i];
        assign wide = {1'b0, base} + {1'b0, ext};
        assign sum[i] = wide[ACC_W-1:0];
        assign lane_ovf[i] = beat_signed
            ? ((base[ACC_W-1] == ext[ACC_W-1]) && (wide[ACC_W-1] != base[ACC_W-1]))
            : wide[ACC_W];
        assign sum_vec[i*ACC_W +: ACC_W] = wide[ACC_W-1:0];
    end

    // out_data is a dedicated register loaded with whatever will be the head next
    // cycle, so it stays stable under backpressure and keeps its value when empty.
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = fifo_count - CNT_ONE;
        end
        next_rd   = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
        head_next = fifo_mem[next_rd];
        if (push && (wr_ptr == next_rd)) begin
            head_next = sum_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
            beat_cnt     <= '0;
            group_len    <= LEN_ONE;
            group_signed <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            out_data     <= '0;
            ovf          <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                for (int i = 0; i < LANES; i++) begin
                    acc[i] <= sum[i];
                end
                if (first_beat) begin
                    group_len    <= beat_len;
                    group_signed <= signed_mode;
                end
                beat_cnt <= last_beat ? '0 : beat_next[LEN_W-1:0];
                if (|lane_ovf) begin
                    ovf <= 1'b1;
                end
            end
            if (push) begin
                fifo_mem[wr_ptr] <= sum_vec;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            fifo_count <= count_next;
            if (count_next != '0) begin
                out_data <= head_next;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: a vector table, hand-written corner sequences and a
// random phase, all checked against a queue-based arithmetic model of the block.
module tb_psum_accumulator;

    localparam int     LANES = 8;
    localparam int     BW    = 8;
    localparam int     ACC_W = 24;
    localparam int     DEPTH = 4;
    localparam longint FULL  = longint'(1) << ACC_W;
    localparam longint HALF  = longint'(1) << (ACC_W - 1);
    localparam longint MASK  = FULL - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         ce;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  res_mac_n;
    logic [7:0]   acc_len;
    logic         signed_mode;
    logic         out_valid;
    logic         out_ready;
    logic [191:0] out_data;
    logic [7:0]   beat_cnt;
    logic         ovf;

    logic         in_ready10;
    logic         out_valid10;
    logic [79:0]  out_data10;
    logic [7:0]   beat_cnt10;
    logic         ovf10;

    int checks = 0;
    int errors = 0;

    // Behavioural model: exact integer lane sums and a queue of finished groups.
    logic [191:0] exp_q[$];
    longint       macc[LANES];
    int           mbeat = 0;
    int           mlen = 1;
    logic         msigned = 1'b0;
    logic         movf = 1'b0;
    logic [191:0] last_out = '0;
    logic         last_known = 1'b0;

    always #5 clk = ~clk;

    psum_accumulator dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .res_mac_n(res_mac_n), .acc_len(acc_len), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt), .ovf(ovf)
    );

    psum_accumulator #(.ACC_W(10)) dut10 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready10),
        .res_mac_n(res_mac_n), .acc_len(acc_len), .signed_mode(signed_mode),
        .out_valid(out_valid10), .out_ready(out_ready), .out_data(out_data10),
        .beat_cnt(beat_cnt10), .ovf(ovf10)
    );

    typedef struct {
        logic       ce;
        logic       in_valid;
        logic [7:0] lane;
        logic [7:0] len;
        logic       sm;
        logic       ro;
        logic [7:0] exp_beat;
        logic       exp_valid;
        int         exp_lane;
    } vec_t;

    vec_t table_v[11];

    function automatic logic [63:0] rep8(input logic [7:0] b);
        logic [63:0] r;
        for (int i = 0; i < LANES; i++) r[i*BW +: BW] = b;
        return r;
    endfunction

    function automatic logic [191:0] rep24(input int v);
        logic [191:0] r;
        logic [23:0]  t;
        t = v[23:0];
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = t;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic iv, input logic [63:0] data,
                                 input logic [7:0] len, input logic sm, input logic ro);
        ce          = c;
        in_valid    = iv;
        res_mac_n   = data;
        acc_len     = len;
        signed_mode = sm;
        out_ready   = ro;
        #2;
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < LANES; i++) macc[i] = 0;
        mbeat      = 0;
        mlen       = 1;
        msigned    = 1'b0;
        movf       = 1'b0;
        last_known = 1'b0;
    endtask

    task automatic model_beat();
        longint       ext;
        longint       exact;
        logic [7:0]   b;
        logic [191:0] vec;
        logic [63:0]  lane_bits;
        vec = '0;
        if (mbeat == 0) begin
            mlen    = (acc_len == 0) ? 1 : int'(acc_len);
            msigned = signed_mode;
            for (int i = 0; i < LANES; i++) macc[i] = 0;
        end
        for (int i = 0; i < LANES; i++) begin
            b   = res_mac_n[i*BW +: BW];
            ext = longint'(b);
            if (msigned && b[7]) ext = ext - 256;
            exact = macc[i] + ext;
            if (msigned) begin
                if (exact > HALF - 1 || exact < -HALF) movf = 1'b1;
                exact = exact & MASK;
                if (exact >= HALF) exact = exact - FULL;
            end else begin
                if (exact > MASK) movf = 1'b1;
                exact = exact & MASK;
            end
            macc[i] = exact;
        end
        mbeat++;
        if (mbeat == mlen) begin
            for (int i = 0; i < LANES; i++) begin
                lane_bits = macc[i];
                vec[i*ACC_W +: ACC_W] = lane_bits[ACC_W-1:0];
            end
            exp_q.push_back(vec);
            mbeat = 0;
        end
    endtask

    task automatic model_check();
        checkOutput("in_ready", 192'(in_ready), 192'(ce && (exp_q.size() < DEPTH)));
        checkOutput("out_valid", 192'(out_valid), 192'(exp_q.size() != 0));
        checkOutput("beat_cnt", 192'(beat_cnt), 192'(mbeat));
        checkOutput("ovf", 192'(ovf), 192'(movf));
        if (exp_q.size() != 0) checkOutput("out_data head", out_data, exp_q[0]);
        else if (last_known) checkOutput("out_data hold", out_data, last_out);
    endtask

    // Checks the model against the DUT, then crosses one rising edge.
    task automatic advance();
        logic acc_ok;
        logic pop_ok;
        model_check();
        acc_ok = ce && in_valid && (exp_q.size() < DEPTH);
        pop_ok = ce && out_ready && (exp_q.size() != 0);
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (pop_ok) exp_q.delete(0);
            if (acc_ok) model_beat();
        end
        if (exp_q.size() != 0) begin
            last_out   = exp_q[0];
            last_known = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 8'd1, 1'b0, 1'b0);
        advance();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           accepted;
        logic [191:0] saved;
        logic [191:0] exp10;

        table_v[0]  = '{1'b1, 1'b1, 8'h03, 8'd4, 1'b1, 1'b1, 8'd0, 1'b0, 0};
        table_v[1]  = '{1'b1, 1'b1, 8'h03, 8'd4, 1'b1, 1'b1, 8'd1, 1'b0, 0};
        table_v[2]  = '{1'b1, 1'b1, 8'h03, 8'd4, 1'b1, 1'b1, 8'd2, 1'b0, 0};
        table_v[3]  = '{1'b1, 1'b1, 8'h03, 8'd4, 1'b1, 1'b1, 8'd3, 1'b0, 0};
        table_v[4]  = '{1'b1, 1'b0, 8'h00, 8'd4, 1'b1, 1'b1, 8'd0, 1'b1, 12};
        table_v[5]  = '{1'b1, 1'b1, 8'hFF, 8'd2, 1'b1, 1'b1, 8'd0, 1'b0, 0};
        table_v[6]  = '{1'b1, 1'b1, 8'h01, 8'd2, 1'b1, 1'b1, 8'd1, 1'b0, 0};
        table_v[7]  = '{1'b1, 1'b1, 8'hFF, 8'd2, 1'b0, 1'b1, 8'd0, 1'b1, 0};
        table_v[8]  = '{1'b1, 1'b1, 8'h01, 8'd2, 1'b0, 1'b1, 8'd1, 1'b0, 0};
        table_v[9]  = '{1'b1, 1'b0, 8'h00, 8'd2, 1'b0, 1'b1, 8'd0, 1'b1, 256};
        table_v[10] = '{1'b1, 1'b0, 8'h00, 8'd2, 1'b0, 1'b1, 8'd0, 1'b0, 0};

        model_reset();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 8'd1, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();

        for (int r = 0; r < 11; r++) begin
            applyStimulus(table_v[r].ce, table_v[r].in_valid, rep8(table_v[r].lane),
                          table_v[r].len, table_v[r].sm, table_v[r].ro);
            checkOutput($sformatf("tbl%0d beat_cnt", r), 192'(beat_cnt), 192'(table_v[r].exp_beat));
            checkOutput($sformatf("tbl%0d out_valid", r), 192'(out_valid), 192'(table_v[r].exp_valid));
            if (table_v[r].exp_valid)
                checkOutput($sformatf("tbl%0d out_data", r), out_data, rep24(table_v[r].exp_lane));
            advance();
        end
        checkOutput("ext ovf", 192'(ovf), 192'(0));

        // Backpressure: five K=1 beats offered into a four-entry FIFO.
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd1, 1'b1, 1'b0);
            if (in_ready && in_valid) accepted++;
            if (i == 4) checkOutput("bp full in_ready", 192'(in_ready), 192'(0));
            advance();
        end
        checkOutput("bp accepted", 192'(accepted), 192'(4));
        applyStimulus(1'b1, 1'b0, '0, 8'd1, 1'b1, 1'b1);
        advance();
        applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd1, 1'b0, 1'b1);
        checkOutput("bp in_ready after pop", 192'(in_ready), 192'(1));
        advance();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, '0, 8'd1, 1'b0, 1'b1);
            advance();
        end

        // Mid-group length change is ignored; acc_len=0 pushes every beat.
        applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd4, 1'b1, 1'b1);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd2, 1'b0, 1'b1);
            if (i == 1) checkOutput("midlen no early push", 192'(out_valid), 192'(0));
            if (i == 2) checkOutput("midlen beat3", 192'(beat_cnt), 192'(3));
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd2, 1'b0, 1'b1);
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd0, 1'b1, 1'b1);
            advance();
        end
        applyStimulus(1'b1, 1'b0, '0, 8'd1, 1'b0, 1'b1);
        advance();

        // Reset mid-group with two FIFO entries pending.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd1, 1'b1, 1'b0);
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd4, 1'b1, 1'b0);
            advance();
        end
        do_reset();
        applyStimulus(1'b1, 1'b0, '0, 8'd2, 1'b1, 1'b1);
        checkOutput("rst out_valid", 192'(out_valid), 192'(0));
        checkOutput("rst beat_cnt", 192'(beat_cnt), 192'(0));
        checkOutput("rst ovf", 192'(ovf), 192'(0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, i < 2, {$urandom, $urandom}, 8'd2, 1'b1, 1'b1);
            advance();
        end

        // ce=0 mid-group freezes beat_cnt and out_data even with out_ready high.
        applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd1, 1'b0, 1'b0);
        advance();
        saved = exp_q[0];
        applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'd4, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, {$urandom, $urandom}, 8'd1, 1'b1, 1'b1);
            checkOutput("ce0 beat_cnt", 192'(beat_cnt), 192'(1));
            checkOutput("ce0 out_data", out_data, saved);
            checkOutput("ce0 in_ready", 192'(in_ready), 192'(0));
            advance();
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, i < 3, {$urandom, $urandom}, 8'd1, 1'b1, 1'b1);
            advance();
        end

        // Narrow accumulator: 8 x 127 wraps to -8 and latches ovf.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, rep8(8'h7F), 8'd8, 1'b1, 1'b1);
            if (i == 4) checkOutput("w10 ovf before wrap", 192'(ovf10), 192'(0));
            advance();
        end
        exp10 = '0;
        for (int i = 0; i < LANES; i++) exp10[i*10 +: 10] = 10'h3F8;
        applyStimulus(1'b1, 1'b0, '0, 8'd8, 1'b1, 1'b1);
        checkOutput("w10 out_valid", 192'(out_valid10), 192'(1));
        checkOutput("w10 out_data", 192'(out_data10), exp10);
        checkOutput("w10 ovf", 192'(ovf10), 192'(1));
        advance();
        applyStimulus(1'b1, 1'b0, '0, 8'd8, 1'b1, 1'b1);
        advance();
        checkOutput("w10 ovf sticky", 192'(ovf10), 192'(1));
        do_reset();
        applyStimulus(1'b1, 1'b0, '0, 8'd1, 1'b0, 1'b1);
        checkOutput("w10 ovf after reset", 192'(ovf10), 192'(0));

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                          {$urandom, $urandom}, 8'($urandom_range(0, 3)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
